// File: rtl/usb_msg_streamer_pkg.sv
// Shared FSM state encoding, ASCII constants and sizing helpers for the message streamer.
package usb_msg_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  // A single slot still needs a 1-bit select so the port never collapses to zero width.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_msg_streamer_if.sv
// Byte-write handshake towards usb_uart: one-cycle write strobe plus data, throttled by uart_wait.
interface usb_msg_streamer_if;
  logic       uart_we;
  logic [7:0] uart_di;
  logic       uart_wait;

  modport master (output uart_we, output uart_di, input uart_wait);
  modport slave  (input uart_we, input uart_di, output uart_wait);
endinterface

// File: rtl/usb_msg_streamer_rom.sv
// Constant byte ROM holding all message slots, slot-major; one-cycle registered read,
// kept registered so the store can be mapped onto block RAM. No backpressure.
module usb_msg_streamer_rom #(
  parameter int unsigned          DEPTH = 128,
  parameter int unsigned          AW    = 7,
  parameter logic [DEPTH*8-1:0]   INIT  = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [7:0]    rd_data
);

  always_ff @(posedge clk) begin
    rd_data <= INIT[{addr, 3'b000} +: 8];
  end

endmodule

// File: rtl/usb_msg_streamer.sv
// Streams one NUL-terminated ROM string per trigger or period tick into usb_uart, LF -> CR LF.
// Four cycles minimum per byte; SEND stalls while uart_wait is high; starts while busy are dropped.
module usb_msg_streamer
  import usb_msg_streamer_pkg::*;
#(
  parameter int unsigned                     NUM_MSGS      = 4,
  parameter int unsigned                     SLOT_LEN      = 32,
  parameter int unsigned                     PERIOD_CYCLES = 48000000,
  parameter bit                              CRLF_EXPAND   = 1'b1,
  parameter logic [NUM_MSGS*SLOT_LEN*8-1:0]  MSG_INIT      = '0
) (
  input  logic                               clk_48mhz,
  input  logic                               resetn,
  input  logic                               mode,
  input  logic                               trigger,
  input  logic [sel_width(NUM_MSGS)-1:0]     msg_sel,
  usb_msg_streamer_if.master                 uart,
  output logic                               busy,
  output logic                               done,
  output logic [15:0]                        sent_count
);

  localparam int unsigned SEL_W  = sel_width(NUM_MSGS);
  localparam int unsigned SLOT_W = $clog2(SLOT_LEN);
  localparam int unsigned IDX_W  = SLOT_W + 1;
  localparam int unsigned DEPTH  = NUM_MSGS * SLOT_LEN;
  localparam int unsigned ROM_AW = $clog2(DEPTH);
  localparam int unsigned PCNT_W = $clog2(PERIOD_CYCLES);

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [SEL_W-1:0]    rr_idx;
  logic [SEL_W-1:0]    rr_next;
  logic [SEL_W-1:0]    trig_sel;
  logic [IDX_W-1:0]    idx;
  logic                cr_pending;
  logic [7:0]          tx_byte;
  logic [PCNT_W-1:0]   period_cnt;
  logic                tick;
  logic [ROM_AW-1:0]   rom_addr;
  logic [7:0]          rom_byte;

  assign tick     = (32'(period_cnt) == PERIOD_CYCLES - 1);
  assign trig_sel = (32'(msg_sel) >= NUM_MSGS) ? SEL_W'(NUM_MSGS - 1) : msg_sel;
  assign rr_next  = (32'(rr_idx) == NUM_MSGS - 1) ? '0 : rr_idx + SEL_W'(1);

  // idx == SLOT_LEN aliases onto byte 0 of the slot; CHECK terminates before that byte is used.
  assign rom_addr = ROM_AW'(32'(sel) * SLOT_LEN + 32'(idx[SLOT_W-1:0]));

  usb_msg_streamer_rom #(
    .DEPTH (DEPTH),
    .AW    (ROM_AW),
    .INIT  (MSG_INIT)
  ) u_rom (
    .clk     (clk_48mhz),
    .addr    (rom_addr),
    .rd_data (rom_byte)
  );

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      sel          <= '0;
      rr_idx       <= '0;
      idx          <= '0;
      cr_pending   <= 1'b0;
      tx_byte      <= '0;
      uart.uart_we <= 1'b0;
      uart.uart_di <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sent_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((!mode && trigger) || (mode && tick)) begin
            sel        <= mode ? rr_idx : trig_sel;
            if (mode) begin
              rr_idx <= rr_next;
            end
            idx        <= '0;
            cr_pending <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (32'(idx) == SLOT_LEN || rom_byte == ASCII_NUL) begin
            state <= ST_FIN;
          end else begin
            // A LF is visited twice: first pass emits CR and parks idx, second emits the LF.
            if (CRLF_EXPAND && rom_byte == ASCII_LF && !cr_pending) begin
              tx_byte    <= ASCII_CR;
              cr_pending <= 1'b1;
            end else begin
              tx_byte    <= rom_byte;
              cr_pending <= 1'b0;
            end
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!uart.uart_wait) begin
            uart.uart_we <= 1'b1;
            uart.uart_di <= tx_byte;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          uart.uart_we <= 1'b0;
          if (!cr_pending) begin
            idx <= idx + IDX_W'(1);
          end
          state <= ST_FETCH;
        end
        ST_FIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          sent_count <= sent_count + 16'd1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
